logic_unit_serial: RTL and testbench

Parametrised, slice-serial bitwise logic unit for the datapath ALU; successor to the fixed 32-bit single-function AND block. Latches two WIDTH-bit operands and an op code on `start`, evaluates one SLICE-bit slice per clock (LSB slice first), and signals completion with a one-cycle `done` pulse plus a zero flag. The block sits beside the multiply/divide units and uses the same start/busy/done handshake, so the control unit sequences it identically.

---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_slice.sv | 31 +++
 rtl/logic_unit_serial.sv | 141 ++++++++++++++
 tb/tb_logic_unit_serial.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the slice-serial logic unit: the 3-bit op-code
//   type with its encodings, and the controller state type.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_ANDN = 3'd6;  // a & ~b
  localparam op_t OP_NOT  = 3'd7;  // ~a, b ignored

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// logic_slice
//   Combinational SLICE-bit bitwise evaluator.
//   Ports: a, b - operand slices; op - operation code; y - result slice.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_t              op,
  output logic [SLICE-1:0] y
);

  // Select the bitwise function for this slice.
  always_comb begin
    y = {SLICE{1'b0}};
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_NOT:  y = ~a;
      default: y = {SLICE{1'b0}};
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// logic_unit_serial
//   Slice-serial bitwise logic unit with a start/busy/done handshake.
//   Operands and op are latched on an accepted start; one SLICE-bit slice of
//   the result is produced per clock, LSB slice first.
//   Ports:
//     clk, reset      - clock, synchronous active-high reset
//     start, op       - request and operation code (sampled when not busy)
//     Ra, Rb          - WIDTH-bit operands
//     Rz              - WIDTH-bit result register
//     busy            - slices being computed
//     done            - one-cycle pulse when Rz is final
//     zero            - Rz == 0, valid only with done
module logic_unit_serial
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic [WIDTH-1:0] Rz,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_check
      $error("logic_unit_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rz_q, rz_d;
  op_t              op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [SLICE-1:0] slice_y_s;

  assign slice_a_s = a_q[k_q*SLICE +: SLICE];
  assign slice_b_s = b_q[k_q*SLICE +: SLICE];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .op (op_q),
    .y  (slice_y_s)
  );

  // Next-state, latch, slice write-enable and flag computation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rz_d    = rz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = Ra;
          b_d     = Rb;
          op_d    = op;
          rz_d    = {WIDTH{1'b0}};
          k_d     = {KW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            rz_d[i*SLICE +: SLICE] = slice_y_s;
          end else begin
            rz_d[i*SLICE +: SLICE] = rz_q[i*SLICE +: SLICE];
          end
        end
        if (k_q == K_LAST) begin
          state_d = DONE;
          k_d     = {KW{1'b0}};
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    zero_d = (state_d == DONE) && (rz_d == {WIDTH{1'b0}});
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= {KW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= OP_AND;
      rz_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rz_q    <= rz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign Rz   = rz_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb_logic_unit_serial
//   Directed bench for logic_unit_serial (default 32/8) plus the 16/16 and
//   64/4 parameter variants, the latter also run against a reference model.
module tb_logic_unit_serial;

  logic clk;
  logic reset;

  // default instance (WIDTH=32, SLICE=8)
  logic        d_start, d_busy, d_done, d_zero;
  logic [2:0]  d_op;
  logic [31:0] d_ra, d_rb, d_rz;

  // WIDTH=16, SLICE=16
  logic        s_start, s_busy, s_done, s_zero;
  logic [2:0]  s_op;
  logic [15:0] s_ra, s_rb, s_rz;

  // WIDTH=64, SLICE=4
  logic        w_start, w_busy, w_done, w_zero;
  logic [2:0]  w_op;
  logic [63:0] w_ra, w_rb, w_rz;

  int checks;
  int failures;

  logic_unit_serial u_dut (
    .clk(clk), .reset(reset), .start(d_start), .op(d_op), .Ra(d_ra), .Rb(d_rb),
    .Rz(d_rz), .busy(d_busy), .done(d_done), .zero(d_zero)
  );

  logic_unit_serial #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .Ra(s_ra), .Rb(s_rb),
    .Rz(s_rz), .busy(s_busy), .done(s_done), .zero(s_zero)
  );

  logic_unit_serial #(.WIDTH(64), .SLICE(4)) u_dut64 (
    .clk(clk), .reset(reset), .start(w_start), .op(w_op), .Ra(w_ra), .Rb(w_rb),
    .Rz(w_rz), .busy(w_busy), .done(w_done), .zero(w_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op on the default instance; returns the cycle number of done
  // (cycle 0 is the start cycle), or 40 if done never appears.
  task automatic run_d(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    d_op = o; d_ra = a; d_rb = b; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    lat = 1;
    while (d_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a,
                                         input logic [63:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      3'd7: return ~a;
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] sweep_exp [8] = '{32'h00000033, 32'h00000077, 32'h00000044, 32'hFFFFFFCC,
                                 32'hFFFFFF88, 32'hFFFFFFBB, 32'h00000004, 32'hFFFFFFC8};

  initial begin
    int lat;
    logic seen_done;
    logic [63:0] w_exp;
    checks = 0; failures = 0;
    reset = 1'b1;
    d_start = 1'b0; d_op = 3'd0; d_ra = 32'd0; d_rb = 32'd0;
    s_start = 1'b0; s_op = 3'd0; s_ra = 16'd0; s_rb = 16'd0;
    w_start = 1'b0; w_op = 3'd0; w_ra = 64'd0; w_rb = 64'd0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_rz",   d_rz,   64'd0);
    chk("rst_busy", d_busy, 64'd0);
    chk("rst_done", d_done, 64'd0);
    chk("rst_zero", d_zero, 64'd0);

    // AND pass-through, with busy visible in cycle 1
    d_op = 3'd0; d_ra = 32'hFFFFFFFF; d_rb = 32'hABCD1234; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("busy_c1", d_busy, 64'd1);
    lat = 1;
    while (d_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("and_lat",  64'(lat), 64'd5);
    chk("and_rz",   d_rz,     64'hABCD1234);
    chk("and_zero", d_zero,   64'd0);
    chk("done_busy", d_busy,  64'd0);
    tick();
    chk("done_pulse", d_done, 64'd0);
    chk("rz_hold",    d_rz,   64'hABCD1234);

    // zero result and the flag going back low after DONE
    run_d(3'd0, 32'hAAAAAAAA, 32'h55555555, lat);
    chk("and0_rz",   d_rz,   64'd0);
    chk("and0_zero", d_zero, 64'd1);
    tick();
    chk("zero_after", d_zero, 64'd0);
    run_d(3'd2, 32'hAAAAAAAA, 32'h55555555, lat);
    chk("xor_rz",   d_rz,   64'hFFFFFFFF);
    chk("xor_zero", d_zero, 64'd0);
    tick();

    // sweep of all ops
    for (int i = 0; i < 8; i++) begin
      run_d(3'(i), 32'h00000037, 32'h00000073, lat);
      chk($sformatf("sweep_op%0d", i), d_rz, 64'(sweep_exp[i]));
      chk($sformatf("sweep_lat%0d", i), 64'(lat), 64'd5);
      tick();
    end

    // start during busy and operand changes are ignored
    d_op = 3'd0; d_ra = 32'hFFFFFFFF; d_rb = 32'h0F0F0F0F; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    d_start = 1'b1; d_op = 3'd1; d_ra = 32'h00000000; d_rb = 32'hFFFFFFFF;
    tick();
    d_start = 1'b0;
    lat = 3;
    while (d_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("ign_lat", 64'(lat), 64'd5);
    chk("ign_rz",  d_rz,     64'h0F0F0F0F);
    // start in the DONE cycle goes straight back to RUN
    run_d(3'd2, 32'hFFFF0000, 32'h00FFFF00, lat);
    chk("b2b_lat", 64'(lat), 64'd5);
    chk("b2b_rz",  d_rz,     64'hFF00FF00);
    tick();

    // reset in cycle 3 of RUN aborts with no done
    d_op = 3'd1; d_ra = 32'h12345678; d_rb = 32'd0; d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", d_busy, 64'd0);
    chk("abort_rz",   d_rz,   64'd0);
    chk("abort_done", d_done, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_nodone", seen_done, 64'd0);
    run_d(3'd5, 32'd0, 32'd0, lat);
    chk("post_abort_lat", 64'(lat), 64'd5);
    chk("post_abort_rz",  d_rz,     64'hFFFFFFFF);
    tick();

    // reset wins over a simultaneous start
    d_start = 1'b1; reset = 1'b1;
    tick();
    d_start = 1'b0; reset = 1'b0;
    chk("rst_start_busy", d_busy, 64'd0);
    tick();
    chk("rst_start_busy2", d_busy, 64'd0);

    // WIDTH=16, SLICE=16: done in cycle 2
    s_op = 3'd3; s_ra = 16'h00FF; s_rb = 16'h0F0F; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 1;
    while (s_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("w16_lat", 64'(lat), 64'd2);
    chk("w16_rz",  s_rz,     64'hFFF0);
    tick();

    // WIDTH=64, SLICE=4 against the reference model, with random aborts
    for (int n = 0; n < 1000; n++) begin
      w_op = 3'($urandom_range(0, 7));
      w_ra = {$urandom, $urandom};
      w_rb = {$urandom, $urandom};
      w_exp = ref_op(w_op, w_ra, w_rb);
      w_start = 1'b1;
      tick();
      w_start = 1'b0;
      w_ra = {$urandom, $urandom};
      w_rb = {$urandom, $urandom};
      w_op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 10)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("w64_abort_busy", w_busy, 64'd0);
        chk("w64_abort_rz",   w_rz,   64'd0);
      end else begin
        lat = 1;
        while (w_done !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("w64_lat",  64'(lat), 64'd17);
        chk("w64_rz",   w_rz,     w_exp);
        chk("w64_zero", w_zero,   64'(w_exp == 64'd0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
